dmem_port_arbiter: RTL

Two-requester arbiter and access sequencer for the single data port of the unified simulation memory. Requester 0 is the core load/store unit and requester 1 is the testbench/DMA loader. Each request is accepted with a valid/ready handshake, replayed onto the memory data port for exactly one cycle, and returned as a registered response with its own valid/ready handshake. The instruction port is not touched by this block.

---
 rtl/dmem_port_arbiter_if.sv | 44 ++++
 rtl/dmem_port_arbiter.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/dmem_port_arbiter_if.sv
// Request/response bundle shared by the two requesters of the data-port arbiter.
// Requester 0 is the core load/store unit; requester 1 is the testbench/DMA loader.
// The master modport is the requester side, and the slave modport is the arbiter side.
interface dmem_port_arbiter_if;
    // requester 0 request channel
    logic        req0_valid;
    logic        req0_ready;
    logic [31:0] req0_addr;
    logic [31:0] req0_wdata;
    logic [3:0]  req0_we;

    // requester 0 response channel
    logic        rsp0_valid;
    logic        rsp0_ready;
    logic [31:0] rsp0_rdata;
    logic        rsp0_err;

    // requester 1 request channel
    logic        req1_valid;
    logic        req1_ready;
    logic [31:0] req1_addr;
    logic [31:0] req1_wdata;
    logic [3:0]  req1_we;

    // requester 1 response channel
    logic        rsp1_valid;
    logic        rsp1_ready;
    logic [31:0] rsp1_rdata;
    logic        rsp1_err;

    modport master (
        output req0_valid, req0_addr, req0_wdata, req0_we, rsp0_ready,
        input  req0_ready, rsp0_valid, rsp0_rdata, rsp0_err,
        output req1_valid, req1_addr, req1_wdata, req1_we, rsp1_ready,
        input  req1_ready, rsp1_valid, rsp1_rdata, rsp1_err
    );

    modport slave (
        input  req0_valid, req0_addr, req0_wdata, req0_we, rsp0_ready,
        output req0_ready, rsp0_valid, rsp0_rdata, rsp0_err,
        input  req1_valid, req1_addr, req1_wdata, req1_we, rsp1_ready,
        output req1_ready, rsp1_valid, rsp1_rdata, rsp1_err
    );
endinterface

// File: rtl/dmem_port_arbiter.sv
// Two-requester arbiter and access sequencer for the data port of the unified
// simulation memory. Each transaction is sequenced as IDLE -> ACCESS -> RESP, and only
// one transaction is in flight at a time.
// Optional feature macro: DMEM_ARB_RR_EN.
//   defined   -> round-robin on ties, tracked by the last_grant register
//   undefined -> fixed priority, requester 0 wins ties
module dmem_port_arbiter #(
    parameter int MEM_WORDS = 2048
) (
    input  logic                  clk,
    input  logic                  rst_n,
    dmem_port_arbiter_if.slave    bus,
    output logic [31:0]           mem_addr,
    output logic [31:0]           mem_wdata,
    output logic [3:0]            mem_we,
    output logic                  mem_re,
    input  logic [31:0]           mem_rdata
);

    localparam logic [31:0] MEM_WORDS_32 = 32'(MEM_WORDS);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;

    logic        grant0;
    logic        grant1;
    logic        prefer0;
    logic        req_fire;
    logic        rsp_fire;

    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;
    logic [3:0]  sel_we;
    logic        sel_oor;

    logic        owner;
    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;
    logic [3:0]  lat_we;
    logic        lat_oor;

    logic [31:0] rsp_rdata;
    logic        rsp_err;

`ifdef DMEM_ARB_RR_EN
    logic        last_grant;

    // Remember who won the most recent handshake; reset to 1 so the first tie goes to requester 0
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_grant <= 1'b1;
        end else if (req_fire) begin
            last_grant <= grant1;
        end
    end

    assign prefer0 = last_grant;
`else
    assign prefer0 = 1'b1;
`endif

    // Arbitration is only open in IDLE and out of reset, so no handshake can complete while rst_n is low
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (state == IDLE && rst_n) begin
            if (bus.req0_valid && (!bus.req1_valid || prefer0)) begin
                grant0 = 1'b1;
            end else if (bus.req1_valid) begin
                grant1 = 1'b1;
            end
        end
    end

    assign req_fire = grant0 | grant1;

    assign bus.req0_ready = grant0;
    assign bus.req1_ready = grant1;

    // Select the winning request's fields and range-check its word index before latching
    always_comb begin
        sel_addr  = bus.req0_addr;
        sel_wdata = bus.req0_wdata;
        sel_we    = bus.req0_we;
        if (grant1) begin
            sel_addr  = bus.req1_addr;
            sel_wdata = bus.req1_wdata;
            sel_we    = bus.req1_we;
        end
        sel_oor = ({2'b00, sel_addr[31:2]} >= MEM_WORDS_32);
    end

    // The response handshake belongs to whichever requester owns the transaction
    assign rsp_fire = (state == RESP) && (owner ? bus.rsp1_ready : bus.rsp0_ready);

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: ACCESS is always a single cycle, and RESP waits for the owner's ready
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (req_fire) state_next = ACCESS;
            ACCESS:  state_next = RESP;
            RESP:    if (rsp_fire) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Latch the accepted request so the requester is free to change its inputs after the handshake
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            owner     <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            lat_we    <= '0;
            lat_oor   <= 1'b0;
        end else if (req_fire) begin
            owner     <= grant1;
            lat_addr  <= sel_addr;
            lat_wdata <= sel_wdata;
            lat_we    <= sel_we;
            lat_oor   <= sel_oor;
        end
    end

    // Capture the response in ACCESS; only in-range reads return memory data
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else if (state == ACCESS) begin
            rsp_rdata <= (!lat_oor && lat_we == 4'b0000) ? mem_rdata : 32'h0;
            rsp_err   <= lat_oor;
        end
    end

    // Drive the memory port only during an in-range ACCESS; strobes are gated by rst_n so reset kills the access
    always_comb begin
        mem_addr       = '0;
        mem_wdata      = '0;
        mem_we         = '0;
        mem_re         = 1'b0;
        bus.rsp0_valid = 1'b0;
        bus.rsp1_valid = 1'b0;
        if (state == ACCESS && !lat_oor) begin
            mem_addr  = lat_addr;
            mem_wdata = lat_wdata;
            mem_we    = lat_we & {4{rst_n}};
            mem_re    = rst_n & (lat_we == 4'b0000);
        end
        if (state == RESP && rst_n) begin
            bus.rsp0_valid = ~owner;
            bus.rsp1_valid = owner;
        end
    end

    assign bus.rsp0_rdata = owner ? 32'h0 : rsp_rdata;
    assign bus.rsp0_err   = ~owner & rsp_err;
    assign bus.rsp1_rdata = owner ? rsp_rdata : 32'h0;
    assign bus.rsp1_err   = owner & rsp_err;

    // Arbitration never grants both requesters together
    a_single_grant: assert property (@(posedge clk) disable iff (!rst_n)
        !(grant0 && grant1));

    // ACCESS never lasts longer than one cycle
    a_access_one_cycle: assert property (@(posedge clk) disable iff (!rst_n)
        (state == ACCESS) |=> (state == RESP));

    // A pending response holds its data until it is consumed
    a_rsp_stable: assert property (@(posedge clk) disable iff (!rst_n)
        (state == RESP && !rsp_fire) |=> ($stable(rsp_rdata) && $stable(rsp_err) && $stable(owner)));

    // The memory strobes stay quiet outside ACCESS
    a_mem_quiet: assert property (@(posedge clk)
        (state != ACCESS) |-> (mem_we == 4'b0000 && !mem_re));

endmodule
